rcc_eth_clk_mon: RTL and testbench
==================================

Name: rcc_eth_clk_mon

Overview:
- Monitors the Ethernet MII/RMII pad clock from the RCC side. It consumes what the ETH kernel clock controller receives from the pad.
- Classifies the pad clock frequency and flags a missing clock. The flag drives the `clk_fail` inputs of the ETH clock switches and the RCC interrupt logic.
- Runs entirely on the RCC reference clock. The input is a divide-by-2 toggle generated by a single flop in the pad clock domain, so each transition equals one pad clock cycle.

Parameters:
- WIN_CYCLES, 1000, measurement window length in `clk` cycles (10 us at 100 MHz)
- CNT_W, 12, width of the edge counter and `edge_cnt`; counter saturates at all-ones
- FAIL_MAX, 2, a window count less than or equal to this value is a failing window
- TH_LO, 100, a count less than or equal to TH_LO (and above FAIL_MAX) classifies as 2.5 MHz
- TH_HI, 375, a count less than or equal to TH_HI (and above TH_LO) classifies as 25 MHz; above TH_HI classifies as 50 MHz
- FAIL_WIN, 2, consecutive failing windows required before `clk_fail` asserts

Ports:
- clk  input  1  RCC reference clock; frequency must exceed 2x the toggle frequency
- rst  input  1  reset, asynchronous, active-high
- mon_en  input  1  monitor enable, synchronous to `clk`
- eth_clk_tgl  input  1  asynchronous divide-by-2 toggle of pad_rcc_eth_mii_rx_clk
- fail_clr  input  1  single-cycle clear of `fail_irq_pend`
- speed  output  2  00 none, 01 2.5 MHz, 10 25 MHz, 11 50 MHz
- edge_cnt  output  CNT_W  edge count of the last completed window
- meas_valid  output  1  at least one window has completed since enable
- clk_fail  output  1  debounced missing-clock flag
- fail_irq_pend  output  1  sticky, set on a 0->1 transition of `clk_fail`

Behaviour:
Reset:
- Every flop clears to 0, including all outputs, synchronizer stages, counters and state.
- State resets to IDLE.
Input path:
- Two synchronizer flops feed a third edge-detect flop.
- edge = s2 ^ s3, asserted for 1 cycle per transition.
- Latency from pad toggle to edge is 3 clk cycles.
FSM:
- IDLE
  - win_cnt = 0, edge counter = 0, synchronizer keeps running.
  - Goes to RUN when mon_en = 1.
- RUN
  - win_cnt increments every cycle.
  - The edge counter increments on edge and saturates at 2^CNT_W - 1.
  - When win_cnt = WIN_CYCLES - 1, goes to EVAL on the next cycle.
  - That final cycle's edge is still counted.
- EVAL (one cycle)
  - Registers edge_cnt <= counter.
  - Registers speed from the thresholds; speed = 00 when count <= FAIL_MAX.
  - Sets meas_valid <= 1.
  - Updates the fail-window counter: increments (saturating at FAIL_WIN) on a failing window, clears on a good window.
  - clk_fail <= (fail-window counter reaches FAIL_WIN).
  - clk_fail deasserts after one good window.
  - win_cnt clears.
  - The edge counter loads 1 if edge is asserted in the EVAL cycle, else 0. The next window loses no edge.
  - Goes to RUN, or to IDLE if mon_en = 0.
Outputs:
- All results become visible the cycle after EVAL.
- Outputs are held constant for the whole following window.
mon_en deassertion:
- Deassertion mid-window (RUN or EVAL) goes to IDLE on the next cycle. The partial window is discarded.
- Clears meas_valid, speed, clk_fail, the fail-window counter and edge_cnt.
- fail_irq_pend is kept.
fail_irq_pend:
- Set the cycle after clk_fail rises.
- Cleared by fail_clr.
- If set and clear occur in the same cycle, set wins.
Re-enable:
- Starts a fresh window, with the first result WIN_CYCLES + 1 cycles later.
Widths:
- win_cnt width is clog2(WIN_CYCLES).
- Threshold comparisons are unsigned at CNT_W bits.

Test Plan:
- 25 MHz pad clock with clk = 100 MHz and mon_en = 1 -> after the first window, edge_cnt within 250±2, speed = 10, meas_valid = 1, clk_fail = 0.
- Pad at 2.5 MHz, then switched to 50 MHz -> windows report speed = 01 (count ~25), then speed = 11 (count ~500) within 2 windows, with no spurious clk_fail.
- Toggle stopped while running at 25 MHz -> first failing window gives clk_fail = 0. The second gives clk_fail = 1 and fail_irq_pend = 1. Restart the clock -> clk_fail = 0 after one good window, with fail_irq_pend still 1 until fail_clr.
- mon_en dropped at win_cnt = 500 -> next cycle state is IDLE and meas_valid/speed/edge_cnt are 0. Re-enable -> first result exactly WIN_CYCLES + 1 cycles later.
- Edge injected exactly in the EVAL cycle -> excluded from the completed edge_cnt and counted in the next window's edge_cnt.
- rst asserted asynchronously mid-window with clk_fail = 1 -> all outputs go to 0 immediately. fail_clr and a clk_fail rise in the same cycle -> fail_irq_pend = 1.

Source files
------------

// File: rtl/rcc_eth_clk_mon.sv
// Ethernet pad clock monitor: counts synchronized divide-by-2 toggle transitions over a
// fixed window of clk cycles, classifies the pad frequency and flags a missing clock.
//
// state | meaning
// IDLE  | monitor disabled, window and edge counters held at zero
// RUN   | counting synchronized toggle edges across the window
// EVAL  | one cycle: publish results, seed the next window
module rcc_eth_clk_mon #(
    parameter int WIN_CYCLES = 1000,
    parameter int CNT_W      = 12,
    parameter int FAIL_MAX   = 2,
    parameter int TH_LO      = 100,
    parameter int TH_HI      = 375,
    parameter int FAIL_WIN   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mon_en,
    input  logic             eth_clk_tgl,
    input  logic             fail_clr,
    output logic [1:0]       speed,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             meas_valid,
    output logic             clk_fail,
    output logic             fail_irq_pend
);
    localparam int WIN_W = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
    localparam int FW_W  = (FAIL_WIN > 0) ? $clog2(FAIL_WIN + 1) : 1;

    localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_FAIL_MAX = CNT_W'(FAIL_MAX);
    localparam logic [CNT_W-1:0] L_TH_LO    = CNT_W'(TH_LO);
    localparam logic [CNT_W-1:0] L_TH_HI    = CNT_W'(TH_HI);
    localparam logic [FW_W-1:0]  L_FAIL_WIN = FW_W'(FAIL_WIN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_EVAL = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic             w_edge;

    logic [WIN_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_edge_cnt;
    logic [1:0]       r_speed;
    logic             r_meas_valid;
    logic             r_clk_fail;
    logic             r_clk_fail_q;
    logic             r_irq_pend;
    logic [FW_W-1:0]  r_fail_cnt;

    logic             w_win_fail;
    logic [FW_W-1:0]  w_fail_cnt_nxt;
    logic [1:0]       w_speed_nxt;

    // s1/s2 resolve metastability; s3 only exists to detect a change on s2
    assign w_edge     = r_s2 ^ r_s3;
    assign w_win_fail = (r_cnt <= L_FAIL_MAX);

    always_comb begin
        w_speed_nxt = 2'b11;
        if (r_cnt <= L_FAIL_MAX) begin
            w_speed_nxt = 2'b00;
        end else if (r_cnt <= L_TH_LO) begin
            w_speed_nxt = 2'b01;
        end else if (r_cnt <= L_TH_HI) begin
            w_speed_nxt = 2'b10;
        end
    end

    always_comb begin
        w_fail_cnt_nxt = '0;
        if (w_win_fail) begin
            w_fail_cnt_nxt = (r_fail_cnt >= L_FAIL_WIN) ? r_fail_cnt : r_fail_cnt + FW_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (mon_en) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (!mon_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_win_cnt == WIN_LAST) begin
                    w_state_nxt = ST_EVAL;
                end
            end
            ST_EVAL: w_state_nxt = mon_en ? ST_RUN : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_s3         <= 1'b0;
            r_win_cnt    <= '0;
            r_cnt        <= '0;
            r_edge_cnt   <= '0;
            r_speed      <= 2'b00;
            r_meas_valid <= 1'b0;
            r_clk_fail   <= 1'b0;
            r_clk_fail_q <= 1'b0;
            r_irq_pend   <= 1'b0;
            r_fail_cnt   <= '0;
        end else begin
            r_s1         <= eth_clk_tgl;
            r_s2         <= r_s1;
            r_s3         <= r_s2;
            r_clk_fail_q <= r_clk_fail;

            // a new rise of clk_fail beats a simultaneous software clear
            if (r_clk_fail && !r_clk_fail_q) begin
                r_irq_pend <= 1'b1;
            end else if (fail_clr) begin
                r_irq_pend <= 1'b0;
            end

            if (!mon_en || r_state == ST_IDLE) begin
                r_win_cnt    <= '0;
                r_cnt        <= '0;
                r_edge_cnt   <= '0;
                r_speed      <= 2'b00;
                r_meas_valid <= 1'b0;
                r_clk_fail   <= 1'b0;
                r_fail_cnt   <= '0;
            end else if (r_state == ST_RUN) begin
                r_win_cnt <= r_win_cnt + WIN_W'(1);
                if (w_edge && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_edge_cnt   <= r_cnt;
                r_speed      <= w_speed_nxt;
                r_meas_valid <= 1'b1;
                r_fail_cnt   <= w_fail_cnt_nxt;
                r_clk_fail   <= (w_fail_cnt_nxt >= L_FAIL_WIN);
                r_win_cnt    <= '0;
                // an edge landing in the EVAL cycle opens the next window
                r_cnt        <= w_edge ? CNT_W'(1) : '0;
            end
        end
    end

    assign speed         = r_speed;
    assign edge_cnt      = r_edge_cnt;
    assign meas_valid    = r_meas_valid;
    assign clk_fail      = r_clk_fail;
    assign fail_irq_pend = r_irq_pend;

endmodule

// File: tb/tb_rcc_eth_clk_mon.sv
// Bench for rcc_eth_clk_mon: pad toggle generator with timestamped transitions and a
// window-level reference model of counts, speed class, fail debounce and sticky pending bit.
module tb_rcc_eth_clk_mon;
    localparam int WIN    = 1000;
    localparam int CNT_W  = 12;
    localparam int PERIOD = WIN + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             mon_en;
    logic             eth_clk_tgl;
    logic             fail_clr;
    logic [1:0]       speed;
    logic [CNT_W-1:0] edge_cnt;
    logic             meas_valid;
    logic             clk_fail;
    logic             fail_irq_pend;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int tgl_half = 0;
    int tgl_ph   = 0;
    int inj_req  = 0;
    int inj_done = 0;
    int stamps[$];

    int         c_en;
    int         win_k;
    int         consec;
    logic       exp_fail;
    logic       exp_pend;
    int         e_cnt;
    logic [1:0] e_spd;
    logic       e_fail;
    logic       e_pend;

    rcc_eth_clk_mon dut (
        .clk           (clk),
        .rst           (rst),
        .mon_en        (mon_en),
        .eth_clk_tgl   (eth_clk_tgl),
        .fail_clr      (fail_clr),
        .speed         (speed),
        .edge_cnt      (edge_cnt),
        .meas_valid    (meas_valid),
        .clk_fail      (clk_fail),
        .fail_irq_pend (fail_irq_pend)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // pad toggle: changes 7 ns after a clk rise, stamped with the current cycle index
    initial begin
        eth_clk_tgl = 1'b0;
        #2;
        forever begin
            #10;
            if (inj_done < inj_req) begin
                inj_done++;
                eth_clk_tgl = ~eth_clk_tgl;
                stamps.push_back(cyc);
            end else if (tgl_half != 0) begin
                tgl_ph++;
                if (tgl_ph >= tgl_half) begin
                    tgl_ph = 0;
                    eth_clk_tgl = ~eth_clk_tgl;
                    stamps.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #5ms;
        failures++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic wait_cyc(input int target);
        if (cyc > target) begin
            failures++;
            $display("FAIL schedule: target cycle %0d already passed, now %0d", target, cyc);
        end
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // a transition stamped in cycle n is seen by the counter at clk edge n+3
    function automatic int model_count(input int k);
        int lo;
        int hi;
        int n;
        lo = (k == 1) ? c_en + 1 : c_en + PERIOD * (k - 1);
        hi = c_en + PERIOD * k - 1;
        n  = 0;
        foreach (stamps[i]) begin
            if (stamps[i] + 3 >= lo && stamps[i] + 3 <= hi) n++;
        end
        return n;
    endfunction

    function automatic logic [1:0] spd_of(input int n);
        if (n <= 2)   return 2'b00;
        if (n <= 100) return 2'b01;
        if (n <= 375) return 2'b10;
        return 2'b11;
    endfunction

    task automatic enable_mon();
        mon_en   = 1'b1;
        c_en     = cyc + 1;
        win_k    = 0;
        consec   = 0;
        exp_fail = 1'b0;
    endtask

    task automatic step_window();
        win_k++;
        wait_cyc(c_en + PERIOD * win_k);
        e_cnt  = model_count(win_k);
        e_spd  = spd_of(e_cnt);
        e_pend = exp_pend;
        if (e_cnt <= 2) begin
            if (consec < 2) consec++;
        end else begin
            consec = 0;
        end
        e_fail = (consec >= 2);
        if (e_fail && !exp_fail) exp_pend = 1'b1;
        exp_fail = e_fail;
    endtask

    task automatic pulse_clr();
        fail_clr = 1'b1;
        wait_cyc(cyc + 1);
        fail_clr = 1'b0;
        exp_pend = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        mon_en   = 1'b0;
        fail_clr = 1'b0;
        exp_pend = 1'b0;
        wait_cyc(3);
        checks++;
        if ({edge_cnt, speed, meas_valid, clk_fail, fail_irq_pend} !== '0) begin
            failures++;
            $display("FAIL reset_hold: got cnt=%0d spd=%0d mv=%0b fail=%0b pend=%0b, exp all 0", edge_cnt, speed, meas_valid, clk_fail, fail_irq_pend);
        end
        rst      = 1'b0;
        tgl_half = 4;
        wait_cyc(cyc + 20);
        checks++;
        if ({edge_cnt, speed, meas_valid, clk_fail, fail_irq_pend} !== '0) begin
            failures++;
            $display("FAIL reset_idle: got cnt=%0d spd=%0d mv=%0b fail=%0b pend=%0b, exp all 0", edge_cnt, speed, meas_valid, clk_fail, fail_irq_pend);
        end
    endtask

    task automatic test_speed_25();
        enable_mon();
        wait_cyc(c_en + WIN);
        checks++;
        if (meas_valid !== 1'b0) begin
            failures++;
            $display("FAIL first_result_early: meas_valid got %0b exp 0", meas_valid);
        end
        for (int i = 0; i < 2; i++) begin
            step_window();
            checks++;
            if ({edge_cnt, speed, meas_valid, clk_fail, fail_irq_pend} !== {CNT_W'(e_cnt), e_spd, 1'b1, e_fail, e_pend}) begin
                failures++;
                $display("FAIL speed25 w%0d: got cnt=%0d spd=%0d mv=%0b fail=%0b pend=%0b, exp cnt=%0d spd=%0d mv=1 fail=%0b pend=%0b", win_k, edge_cnt, speed, meas_valid, clk_fail, fail_irq_pend, e_cnt, e_spd, e_fail, e_pend);
            end
            checks++;
            if (edge_cnt < 248 || edge_cnt > 252 || speed !== 2'b10 || clk_fail !== 1'b0) begin
                failures++;
                $display("FAIL speed25_range w%0d: got cnt=%0d spd=%0d fail=%0b, exp cnt 248..252 spd=2 fail=0", win_k, edge_cnt, speed, clk_fail);
            end
        end
    endtask

    task automatic test_speed_change();
        for (int ph = 0; ph < 2; ph++) begin
            tgl_half = (ph == 0) ? 40 : 2;
            for (int i = 0; i < 3; i++) begin
                step_window();
                checks++;
                if ({edge_cnt, speed, meas_valid, clk_fail, fail_irq_pend} !== {CNT_W'(e_cnt), e_spd, 1'b1, e_fail, e_pend}) begin
                    failures++;
                    $display("FAIL speed_change p%0d w%0d: got cnt=%0d spd=%0d mv=%0b fail=%0b pend=%0b, exp cnt=%0d spd=%0d mv=1 fail=%0b pend=%0b", ph, win_k, edge_cnt, speed, meas_valid, clk_fail, fail_irq_pend, e_cnt, e_spd, e_fail, e_pend);
                end
            end
            checks++;
            if (speed !== ((ph == 0) ? 2'b01 : 2'b11) || clk_fail !== 1'b0) begin
                failures++;
                $display("FAIL speed_change_class p%0d: got spd=%0d fail=%0b, exp spd=%0d fail=0", ph, speed, clk_fail, (ph == 0) ? 1 : 3);
            end
        end
    endtask

    task automatic test_fail();
        for (int i = 0; i < 4; i++) begin
            tgl_half = (i == 1 || i == 2) ? 0 : 4;
            step_window();
            checks++;
            if ({edge_cnt, speed, meas_valid, clk_fail, fail_irq_pend} !== {CNT_W'(e_cnt), e_spd, 1'b1, e_fail, e_pend}) begin
                failures++;
                $display("FAIL fail_seq w%0d: got cnt=%0d spd=%0d mv=%0b fail=%0b pend=%0b, exp cnt=%0d spd=%0d mv=1 fail=%0b pend=%0b", win_k, edge_cnt, speed, meas_valid, clk_fail, fail_irq_pend, e_cnt, e_spd, e_fail, e_pend);
            end
            if (i == 2) begin
                checks++;
                if (clk_fail !== 1'b1 || fail_irq_pend !== 1'b0) begin
                    failures++;
                    $display("FAIL fail_rise: got fail=%0b pend=%0b, exp fail=1 pend=0", clk_fail, fail_irq_pend);
                end
                wait_cyc(cyc + 1);
                checks++;
                if (fail_irq_pend !== 1'b1) begin
                    failures++;
                    $display("FAIL pend_set: got pend=%0b exp 1", fail_irq_pend);
                end
            end
        end
        checks++;
        if (clk_fail !== 1'b0 || fail_irq_pend !== 1'b1) begin
            failures++;
            $display("FAIL fail_recover: got fail=%0b pend=%0b, exp fail=0 pend=1", clk_fail, fail_irq_pend);
        end
        pulse_clr();
        checks++;
        if (fail_irq_pend !== 1'b0) begin
            failures++;
            $display("FAIL pend_clear: got pend=%0b exp 0", fail_irq_pend);
        end
    endtask

    task automatic test_disable();
        int base;
        base = c_en + PERIOD * win_k;
        wait_cyc(base + 500);
        mon_en = 1'b0;
        wait_cyc(base + 501);
        consec   = 0;
        exp_fail = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({edge_cnt, speed, meas_valid, clk_fail, fail_irq_pend} !== {{(CNT_W + 4){1'b0}}, exp_pend}) begin
                failures++;
                $display("FAIL disable_%0d: got cnt=%0d spd=%0d mv=%0b fail=%0b pend=%0b, exp zeros pend=%0b", i, edge_cnt, speed, meas_valid, clk_fail, fail_irq_pend, exp_pend);
            end
            wait_cyc(cyc + 10);
        end
        enable_mon();
        wait_cyc(c_en + WIN);
        checks++;
        if (meas_valid !== 1'b0) begin
            failures++;
            $display("FAIL reenable_early: meas_valid got %0b exp 0", meas_valid);
        end
        step_window();
        checks++;
        if ({edge_cnt, speed, meas_valid, clk_fail, fail_irq_pend} !== {CNT_W'(e_cnt), e_spd, 1'b1, e_fail, e_pend}) begin
            failures++;
            $display("FAIL reenable_w1: got cnt=%0d spd=%0d mv=%0b fail=%0b pend=%0b, exp cnt=%0d spd=%0d mv=1 fail=%0b pend=%0b", edge_cnt, speed, meas_valid, clk_fail, fail_irq_pend, e_cnt, e_spd, e_fail, e_pend);
        end
    endtask

    task automatic test_eval_edge();
        tgl_half = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                wait_cyc(c_en + PERIOD * (win_k + 1) - 3);
                inj_req++;
            end
            step_window();
            checks++;
            if ({edge_cnt, speed, meas_valid, clk_fail, fail_irq_pend} !== {CNT_W'(e_cnt), e_spd, 1'b1, e_fail, e_pend}) begin
                failures++;
                $display("FAIL eval_edge w%0d: got cnt=%0d spd=%0d mv=%0b fail=%0b pend=%0b, exp cnt=%0d spd=%0d mv=1 fail=%0b pend=%0b", win_k, edge_cnt, speed, meas_valid, clk_fail, fail_irq_pend, e_cnt, e_spd, e_fail, e_pend);
            end
            if (i >= 2) begin
                checks++;
                if (edge_cnt !== CNT_W'(i - 2)) begin
                    failures++;
                    $display("FAIL eval_edge_split w%0d: got cnt=%0d exp %0d", win_k, edge_cnt, i - 2);
                end
            end
        end
    endtask

    task automatic test_reset_async();
        checks++;
        if (clk_fail !== 1'b1) begin
            failures++;
            $display("FAIL async_pre: clk_fail got %0b exp 1", clk_fail);
        end
        #3;
        rst    = 1'b1;
        mon_en = 1'b0;
        #1;
        checks++;
        if ({edge_cnt, speed, meas_valid, clk_fail, fail_irq_pend} !== '0) begin
            failures++;
            $display("FAIL async_rst: got cnt=%0d spd=%0d mv=%0b fail=%0b pend=%0b, exp all 0", edge_cnt, speed, meas_valid, clk_fail, fail_irq_pend);
        end
        wait_cyc(cyc + 2);
        rst      = 1'b0;
        exp_pend = 1'b0;
        wait_cyc(cyc + 2);
        enable_mon();
        for (int i = 0; i < 2; i++) begin
            step_window();
            checks++;
            if ({edge_cnt, speed, meas_valid, clk_fail, fail_irq_pend} !== {CNT_W'(e_cnt), e_spd, 1'b1, e_fail, e_pend}) begin
                failures++;
                $display("FAIL clr_race w%0d: got cnt=%0d spd=%0d mv=%0b fail=%0b pend=%0b, exp cnt=%0d spd=%0d mv=1 fail=%0b pend=%0b", win_k, edge_cnt, speed, meas_valid, clk_fail, fail_irq_pend, e_cnt, e_spd, e_fail, e_pend);
            end
        end
        fail_clr = 1'b1;
        wait_cyc(cyc + 1);
        fail_clr = 1'b0;
        checks++;
        if (fail_irq_pend !== 1'b1) begin
            failures++;
            $display("FAIL set_beats_clr: got pend=%0b exp 1", fail_irq_pend);
        end
        pulse_clr();
        checks++;
        if (fail_irq_pend !== 1'b0) begin
            failures++;
            $display("FAIL clr_after_race: got pend=%0b exp 0", fail_irq_pend);
        end
    endtask

    task automatic test_random();
        int opts[10];
        opts = '{0, 2, 3, 4, 8, 10, 20, 40, 60, 0};
        tgl_ph = int'($urandom_range(0, 3));
        for (int i = 0; i < 8; i++) begin
            wait_cyc(cyc + int'($urandom_range(1, 990)));
            tgl_half = opts[$urandom_range(0, 9)];
            if ($urandom_range(0, 1) == 1) pulse_clr();
            step_window();
            checks++;
            if ({edge_cnt, speed, meas_valid, clk_fail, fail_irq_pend} !== {CNT_W'(e_cnt), e_spd, 1'b1, e_fail, e_pend}) begin
                failures++;
                $display("FAIL random w%0d half=%0d: got cnt=%0d spd=%0d mv=%0b fail=%0b pend=%0b, exp cnt=%0d spd=%0d mv=1 fail=%0b pend=%0b", win_k, tgl_half, edge_cnt, speed, meas_valid, clk_fail, fail_irq_pend, e_cnt, e_spd, e_fail, e_pend);
            end
        end
    endtask

    initial begin
        test_reset();
        test_speed_25();
        test_speed_change();
        test_fail();
        test_disable();
        test_eval_edge();
        test_reset_async();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
